rom_loader: RTL
===============

Name: rom_loader

Overview:
- Write-side initiator for the 64 KiB byte-addressed program memory.
- Accepts a framed byte stream from a host link (UART/SPI front end) over a valid/ready handshake and writes the payload into memory through its address/write-enable/data port.
- Optionally reads the payload back to verify it, and holds the CPU in reset until a good image is loaded.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
VERIFY, 1, 1 = read back and re-checksum the payload after writing; 0 = skip
TIMEOUT_CYCLES, 1048575, max idle cycles between bytes inside a frame; 0 disables

Ports:
clock_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
s_data_i  in  8  stream byte
s_valid_i  in  1  stream byte valid
s_ready_o  out  1  loader accepts byte (handshake = s_valid_i & s_ready_o)
mem_address_o  out  16  memory byte address
mem_write_enable_o  out  1  memory write strobe, one byte per cycle
mem_data_o  out  8  memory write data
mem_data_i  in  8  memory read data, valid 1 cycle after address (registered memory)
busy_o  out  1  frame in progress
done_o  out  1  last frame loaded and verified OK (sticky)
error_o  out  1  last frame failed: checksum, verify or timeout (sticky)
cpu_hold_o  out  1  hold CPU in reset

Behaviour:
- Frame format: SYNC, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN data bytes, CHK.
  - LEN = 0 means 65536 bytes; the length counter is 17 bits.
  - CHK is valid when (sum of data bytes + CHK) mod 256 = 0.
- Reset values:
  - s_ready_o = 0, mem_write_enable_o = 0, mem_address_o = 0, mem_data_o = 0, busy_o = 0, done_o = 0, error_o = 0.
  - cpu_hold_o = 1, state = IDLE; all counters and accumulators cleared.
  - Reset mid-frame aborts immediately. Memory contents already written are left as they are.
- States:
  - IDLE: s_ready_o = 1. A byte equal to SYNC_BYTE moves to ADDR_HI, sets busy_o = 1 and cpu_hold_o = 1, and clears done_o and error_o. Any other byte is consumed and discarded.
  - ADDR_HI, ADDR_LO, LEN_HI, LEN_LO: s_ready_o = 1; one byte each, latched into the start address and length. LEN_LO moves to DATA.
  - DATA: s_ready_o = 1. Each handshake registers a write in the next cycle: mem_write_enable_o = 1, mem_address_o = current address, mem_data_o = byte. Then address += 1 modulo 2^16 (0xFFFF wraps to 0x0000), sum += byte mod 256, remaining -= 1. Remaining reaching 0 moves to CHK. Throughput is one byte per cycle; back-to-back valid must be accepted.
  - CHK: s_ready_o = 1. If sum + CHK ≠ 0 mod 256, go to FAIL. Otherwise go to VERIFY if VERIFY = 1, else go to PASS.
  - VERIFY: s_ready_o = 0; no writes.
    - Re-issue start address and length. Present one address per cycle (address wrap as in DATA).
    - Accumulate mem_data_i one cycle after each address. One drain cycle follows the last address.
    - Readback sum equal to the received data sum goes to PASS, else FAIL.
  - PASS: one cycle; done_o = 1, busy_o = 0, cpu_hold_o = 0; return to IDLE.
  - FAIL: one cycle; error_o = 1, busy_o = 0, cpu_hold_o stays 1; return to IDLE.
- Timeout:
  - In ADDR_HI through CHK, an idle counter resets on each handshake.
  - When it reaches TIMEOUT_CYCLES the frame goes to FAIL.
  - The counter is not active in IDLE or VERIFY.
- A SYNC_BYTE value inside header or data is treated as ordinary data (no resync).
- mem_write_enable_o is never asserted outside the cycle after a DATA handshake.
- cpu_hold_o is released only by PASS. It stays deasserted in IDLE after a PASS and is reasserted by the next SYNC.

Decomposition:
- Package rom_loader_pkg holds the state enum and constants: default SYNC_BYTE, 17-bit length width, 16-bit address width.
- One sub-module is natural: rom_loader_sum, an 8-bit mod-256 accumulator with clear and enable, instantiated twice (write path and verify path).

Test Plan:
- Frame A5 12 34 00 04 | 01 02 03 04 | F6 with memory model -> writes 0x1234..0x1237 = 01..04, one per cycle; then 4 verify reads; done_o = 1, cpu_hold_o = 0, error_o = 0.
- Same frame with CHK = F5 -> no VERIFY state entered; error_o = 1, cpu_hold_o = 1, done_o = 0.
- Frame at FF FE with LEN 00 04 -> writes land at FFFE, FFFF, 0000, 0001; verify reads the same addresses; done_o = 1.
- Memory model corrupts byte at 0x1236 to 0x13 -> checksum passes, verify sum mismatches -> error_o = 1.
- TIMEOUT_CYCLES = 16; stall 20 cycles after ADDR_LO -> error_o = 1 at idle cycle 16; next A5 clears error_o and busy_o rises.
- Garbage 00 FF 5A, then a valid frame, with reset_i pulsed mid-DATA on a second frame -> garbage ignored; after reset all outputs are at reset values and cpu_hold_o = 1.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// +--------------------------------------------------------------------+
// | rom_loader_pkg : shared types/constants for the program-memory loader | Rev 1.0
// +--------------------------------------------------------------------+
`default_nettype none

package rom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         ADDR_W            = 16;
  localparam int         LEN_W             = 17;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_LEN_HI  = 4'd3,
    ST_LEN_LO  = 4'd4,
    ST_DATA    = 4'd5,
    ST_CHK     = 4'd6,
    ST_VERIFY  = 4'd7,
    ST_PASS    = 4'd8,
    ST_FAIL    = 4'd9
  } state_t;

  // A zero length field encodes a full 64 KiB image.
  function automatic logic [LEN_W-1:0] len_to_count(input logic [ADDR_W-1:0] len);
    return (len == '0) ? 17'h10000 : {1'b0, len};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_loader_sum.sv
// +--------------------------------------------------------------------+
// | rom_loader_sum : mod-256 byte accumulator with clear and enable      | Rev 1.0
// +--------------------------------------------------------------------+
`default_nettype none

module rom_loader_sum
  import rom_loader_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_clear,
  input  logic  i_en,
  input  byte_t i_byte,
  output byte_t o_sum
);

  byte_t r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + i_byte;
    end
  end

  assign o_sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/rom_loader.sv
// +--------------------------------------------------------------------+
// | rom_loader : framed byte stream -> program memory writer w/ verify  | Rev 1.0
// +--------------------------------------------------------------------+
`default_nettype none

module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter bit          VERIFY         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_write_enable_o,
  output logic [7:0]        mem_data_o,
  input  logic [7:0]        mem_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              cpu_hold_o
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state, w_next;
  logic              r_ready, r_we, r_busy, r_done, r_error, r_hold;
  logic              r_rd_s1, r_rd_s2;
  logic [ADDR_W-1:0] r_start, r_len, r_addr, r_mem_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [7:0]        r_mem_data;
  logic [TMO_W-1:0]  r_idle;

  logic  w_hs, w_start, w_active, w_timeout, w_rd_issue, w_verify_end, w_ready_next;
  byte_t w_wr_sum, w_rd_sum, w_chk_total;

  assign w_hs         = s_valid_i & r_ready;
  assign w_start      = w_hs && (r_state == ST_IDLE) && (s_data_i == SYNC_BYTE);
  assign w_active     = (r_state inside {ST_ADDR_HI, ST_ADDR_LO, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK});
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && w_active && !w_hs && (r_idle == TMO_LAST);
  assign w_chk_total  = w_wr_sum + s_data_i;
  assign w_rd_issue   = (r_state == ST_VERIFY) && (r_remaining != '0);
  // Readback is complete once every address is issued and its data has drained through.
  assign w_verify_end = (r_state == ST_VERIFY) && (r_remaining == '0) && !r_rd_s1 && !r_rd_s2;
  assign w_ready_next = (w_next != ST_VERIFY) && (w_next != ST_PASS) && (w_next != ST_FAIL);

  rom_loader_sum u_wr_sum (
    .clk     (clock_i),
    .rst     (reset_i),
    .i_clear (w_start),
    .i_en    (w_hs && (r_state == ST_DATA)),
    .i_byte  (s_data_i),
    .o_sum   (w_wr_sum)
  );

  rom_loader_sum u_rd_sum (
    .clk     (clock_i),
    .rst     (reset_i),
    .i_clear (w_start),
    .i_en    (r_rd_s2),
    .i_byte  (mem_data_i),
    .o_sum   (w_rd_sum)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = ST_ADDR_HI;
      ST_ADDR_HI: if (w_hs) w_next = ST_ADDR_LO;
      ST_ADDR_LO: if (w_hs) w_next = ST_LEN_HI;
      ST_LEN_HI:  if (w_hs) w_next = ST_LEN_LO;
      ST_LEN_LO:  if (w_hs) w_next = ST_DATA;
      ST_DATA:    if (w_hs && (r_remaining == LEN_W'(1))) w_next = ST_CHK;
      ST_CHK: begin
        if (w_hs) begin
          if (w_chk_total != 8'h00) w_next = ST_FAIL;
          else if (VERIFY)          w_next = ST_VERIFY;
          else                      w_next = ST_PASS;
        end
      end
      ST_VERIFY:  if (w_verify_end) w_next = (w_rd_sum == w_wr_sum) ? ST_PASS : ST_FAIL;
      ST_PASS:    w_next = ST_IDLE;
      ST_FAIL:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_FAIL;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_hold      <= 1'b1;
      r_rd_s1     <= 1'b0;
      r_rd_s2     <= 1'b0;
      r_start     <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_remaining <= '0;
      r_idle      <= '0;
    end else begin
      r_ready <= w_ready_next;
      r_we    <= 1'b0;
      r_rd_s1 <= w_rd_issue;
      r_rd_s2 <= r_rd_s1;

      if (!w_active || w_hs) r_idle <= '0;
      else                   r_idle <= r_idle + 1'b1;

      if (w_start) begin
        r_busy  <= 1'b1;
        r_hold  <= 1'b1;
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end

      if (w_hs) begin
        case (r_state)
          ST_ADDR_HI: r_start[15:8] <= s_data_i;
          ST_ADDR_LO: r_start[7:0]  <= s_data_i;
          ST_LEN_HI:  r_len[15:8]   <= s_data_i;
          ST_LEN_LO: begin
            r_len[7:0]  <= s_data_i;
            r_addr      <= r_start;
            r_remaining <= len_to_count({r_len[15:8], s_data_i});
          end
          ST_DATA: begin
            r_we        <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_data  <= s_data_i;
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
          ST_CHK: begin
            r_addr      <= r_start;
            r_remaining <= len_to_count(r_len);
          end
          default: ;
        endcase
      end

      if (w_rd_issue) begin
        r_mem_addr  <= r_addr;
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end

      if (w_next == ST_PASS) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_hold <= 1'b0;
      end
      if (w_next == ST_FAIL) begin
        r_error <= 1'b1;
        r_busy  <= 1'b0;
      end
    end
  end

  assign s_ready_o          = r_ready;
  assign mem_address_o      = r_mem_addr;
  assign mem_write_enable_o = r_we;
  assign mem_data_o         = r_mem_data;
  assign busy_o             = r_busy;
  assign done_o             = r_done;
  assign error_o            = r_error;
  assign cpu_hold_o         = r_hold;

endmodule

`default_nettype wire
